sci_tx_ser: RTL and testbench

Serial transmit stage of the SCI link: the producer of the LVDS bit stream that the SCI receive path samples.
- Accepts 10-bit encoded symbols through a valid/ready handshake.
- Serializes them LSB-first at clk/CLK_DIV (20 Mb/s from 80 MHz).
- Inserts the 30-bit comma triplet at start-up, while idle, and periodically, so the receiver can realign its word boundary.

---
 rtl/sci_tx_ser.sv | 147 ++++++++++++++
 tb/tb_sci_tx_ser.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sci_tx_ser.sv
// SCI serial transmit stage: 10-bit symbols in via valid/ready, LSB-first bit stream
// out at clk/CLK_DIV, with comma triplets at start-up, when idle and every SYNC_INTERVAL words.
module sci_tx_ser #(
  parameter int unsigned CLK_DIV       = 4,
  parameter logic [9:0]  COMMA_A       = 10'b1010000011,
  parameter logic [9:0]  COMMA_B       = 10'b0101111100,
  parameter int unsigned SYNC_INTERVAL = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       LVDS,
  output logic       sync_active,
  output logic       word_done
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned SCNT_W = $clog2(SYNC_INTERVAL + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(2);
  localparam logic [SCNT_W-1:0] SYNC_MAX = SCNT_W'(SYNC_INTERVAL);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [SEL_W-1:0]    word_sel, word_sel_nx;
  logic [SCNT_W-1:0]   sync_cnt, sync_cnt_nx;
  logic [WORD_W-1:0]   shift_reg, shift_nx;
  logic [WORD_W-1:0]   hold_reg, hold_nx;
  logic                hold_full, hold_full_nx;
  logic                din_ready_nx;
  logic                word_done_nx;
  logic                boundary_c;
  logic                pre_boundary_c;
  logic                accept_c;
  logic                load_c;
  logic                will_load_c;
  logic                triplet_busy_c;

  // Next-state, word selection at boundaries and handshake prediction
  always_comb begin
    state_nx       = state;
    word_sel_nx    = word_sel;
    sync_cnt_nx    = sync_cnt;
    shift_nx       = shift_reg;
    hold_nx        = hold_reg;
    load_c         = 1'b0;
    div_cnt_nx     = div_cnt;
    bit_cnt_nx     = bit_cnt;

    boundary_c     = (bit_cnt == BIT_LAST) && (div_cnt == DIV_LAST);
    pre_boundary_c = (bit_cnt == BIT_LAST) && (div_cnt == DIV_PRE);
    accept_c       = din_valid && din_ready;
    triplet_busy_c = (state == ST_SYNC) && (word_sel < SEL_LAST);

    if (div_cnt == DIV_LAST) begin
      div_cnt_nx = '0;
      bit_cnt_nx = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end else begin
      div_cnt_nx = div_cnt + DIV_W'(1);
    end

    if (boundary_c) begin
      if (triplet_busy_c) begin
        word_sel_nx = word_sel + SEL_W'(1);
        shift_nx    = (word_sel == '0) ? COMMA_B : COMMA_A;
      end else if (sync_cnt == SYNC_MAX) begin
        state_nx    = ST_SYNC;
        word_sel_nx = '0;
        sync_cnt_nx = '0;
        shift_nx    = COMMA_A;
      end else if (hold_full) begin
        state_nx    = ST_DATA;
        shift_nx    = hold_reg;
        sync_cnt_nx = sync_cnt + SCNT_W'(1);
        load_c      = 1'b1;
      end else begin
        state_nx    = ST_SYNC;
        word_sel_nx = '0;
        shift_nx    = COMMA_A;
      end
    end

    if (accept_c) begin
      hold_nx = din;
    end
    hold_full_nx = (hold_full && !load_c) || accept_c;

    // Open the handshake in the boundary cycle whenever the held word leaves then,
    // so a new symbol can slip in on the same edge and the line stays gap-free.
    will_load_c  = pre_boundary_c && hold_full_nx && !triplet_busy_c && (sync_cnt != SYNC_MAX);
    din_ready_nx = !hold_full_nx || will_load_c;
    word_done_nx = pre_boundary_c;
  end

  // Serializer state register; resets into the first comma word so start-up is a triplet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nx;
    end
  end

  // Counters, holding register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      word_sel    <= '0;
      sync_cnt    <= '0;
      shift_reg   <= COMMA_A;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      din_ready   <= 1'b0;
      LVDS        <= 1'b0;
      sync_active <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      word_sel    <= word_sel_nx;
      sync_cnt    <= sync_cnt_nx;
      shift_reg   <= shift_nx;
      hold_reg    <= hold_nx;
      hold_full   <= hold_full_nx;
      din_ready   <= din_ready_nx;
      LVDS        <= shift_reg[bit_cnt];
      sync_active <= (state == ST_SYNC);
      word_done   <= word_done_nx;
    end
  end

endmodule

// File: tb/tb_sci_tx_ser.sv
// Bench for sci_tx_ser: word-level line model plus a bit-sampling receiver scoreboard,
// driven by idle, single-word, streaming, mid-word reset and random traffic.
module tb_sci_tx_ser;

  localparam int CLK_DIV    = 4;
  localparam int SI         = 4;
  localparam int WORD_CLKS  = CLK_DIV * 10;
  localparam logic [9:0] CA = 10'b1010000011;
  localparam logic [9:0] CB = 10'b0101111100;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       lvds;
  logic       sync_active;
  logic       word_done;

  always #5 clk = ~clk;

  sci_tx_ser #(
    .CLK_DIV       (CLK_DIV),
    .COMMA_A       (CA),
    .COMMA_B       (CB),
    .SYNC_INTERVAL (SI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .LVDS        (lvds),
    .sync_active (sync_active),
    .word_done   (word_done)
  );

  int         checks;
  int         errors;
  int         c;
  logic       exp_line[$];
  logic       exp_sync[$];
  logic [9:0] hold_q[$];
  logic [9:0] sb_q[$];
  logic       m_in_sync;
  int         m_comma;
  int         m_sent;
  logic [9:0] rx_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  task automatic push_word(input logic [9:0] w, input logic s);
    for (int b = 0; b < 10; b++) begin
      for (int d = 0; d < CLK_DIV; d++) begin
        exp_line.push_back(w[b]);
        exp_sync.push_back(s);
      end
    end
  endtask

  task automatic model_reset();
    c = 0;
    exp_line.delete();
    exp_sync.delete();
    hold_q.delete();
    sb_q.delete();
    m_in_sync = 1'b1;
    m_comma   = 0;
    m_sent    = 0;
    rx_word   = '0;
    push_word(CA, 1'b1);
  endtask

  // One clock: predict handshake/boundary behaviour, advance, compare the line
  task automatic cycle();
    int   ph;
    int   co;
    int   bi;
    logic load;
    logic exp_rdy;
    logic eb;
    logic es;
    ph   = c % WORD_CLKS;
    load = 1'b0;
    if (ph == WORD_CLKS - 1) begin
      if (m_in_sync && m_comma < 2) begin
        m_comma++;
        if (m_comma == 1) push_word(CB, 1'b1);
        else push_word(CA, 1'b1);
      end else if (m_sent == SI) begin
        m_in_sync = 1'b1;
        m_comma   = 0;
        m_sent    = 0;
        push_word(CA, 1'b1);
      end else if (hold_q.size() > 0) begin
        m_in_sync = 1'b0;
        push_word(hold_q[0], 1'b0);
        load = 1'b1;
        m_sent++;
      end else begin
        m_in_sync = 1'b1;
        m_comma   = 0;
        push_word(CA, 1'b1);
      end
    end
    exp_rdy = (c == 0) ? 1'b0 : ((hold_q.size() == 0) || load);
    check("din_ready", 32'(din_ready), 32'(exp_rdy));
    check("word_done", 32'(word_done), 32'(ph == WORD_CLKS - 1));
    if (load) void'(hold_q.pop_front());
    if (din_valid && exp_rdy) hold_q.push_back(din);
    if (din_valid && din_ready) sb_q.push_back(din);
    @(posedge clk);
    #1;
    co = c;
    c++;
    if (exp_line.size() == 0) begin
      check("line_underflow", 32'(1), 32'(0));
    end else begin
      eb = exp_line.pop_front();
      es = exp_sync.pop_front();
      check("lvds", 32'(lvds), 32'(eb));
      check("sync_active", 32'(sync_active), 32'(es));
    end
    // Receiver: sample mid-bit, decode a word at its last bit
    if ((co % CLK_DIV) == CLK_DIV / 2) begin
      bi = (co % WORD_CLKS) / CLK_DIV;
      rx_word[bi] = lvds;
      if (bi == 9) begin
        if (sync_active) begin
          check("rx_comma", 32'((rx_word == CA) || (rx_word == CB)), 32'(1));
        end else if (sb_q.size() == 0) begin
          check("rx_unexpected_data", 32'(rx_word), 32'h3ff_ffff);
        end else begin
          check("rx_data", 32'(rx_word), 32'(sb_q.pop_front()));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rst_lvds", 32'(lvds), 32'(0));
    check("rst_din_ready", 32'(din_ready), 32'(0));
    check("rst_sync_active", 32'(sync_active), 32'(0));
    check("rst_word_done", 32'(word_done), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [9:0] src;
  logic       acc;
  logic       found;

  initial begin
    checks    = 0;
    errors    = 0;
    c         = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    src       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lvds", 32'(lvds), 32'(0));
    check("reset_din_ready", 32'(din_ready), 32'(0));
    check("reset_sync_active", 32'(sync_active), 32'(0));
    check("reset_word_done", 32'(word_done), 32'(0));
    rst = 1'b0;
    model_reset();

    // Idle: continuous comma triplets
    repeat (130) cycle();

    // Single symbol during the start-up triplet
    do_reset();
    repeat (10) cycle();
    din_valid = 1'b1;
    din       = 10'h2A5;
    cycle();
    din_valid = 1'b0;
    repeat (160) cycle();

    // Saturated incrementing source, includes boundary-cycle accepts
    din_valid = 1'b1;
    repeat (800) begin
      din = src;
      acc = din_valid && din_ready;
      cycle();
      if (acc) src++;
    end

    // Reset while bit 5 of a data word is being sent
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (!m_in_sync && ((c % WORD_CLKS) / CLK_DIV) == 5) begin
        found = 1'b1;
      end else begin
        din = src;
        acc = din_valid && din_ready;
        cycle();
        if (acc) src++;
      end
    end
    check("bit5_reached", 32'(found), 32'(1));
    do_reset();
    repeat (200) cycle();

    // Random traffic
    repeat (1500) begin
      din_valid = 1'($urandom_range(0, 1));
      din       = 10'($urandom);
      cycle();
    end
    din_valid = 1'b0;
    repeat (2 * WORD_CLKS) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
